alu: RTL and testbench
======================

# alu

16-bit two's-complement adder with a five-flag status word (sign, zero, carry, parity, overflow) and a registered result stage. It is the arithmetic core of the datapath. It takes two 16-bit operands, forms their sum with four chained 4-bit carry-lookahead blocks, and presents the sum plus flags one clock later.

## Interface
- Parameters: none. Datapath width is fixed at 16 bits.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on X/Y are valid this cycle; load result register
- X  input  16  operand A, two's complement
- Y  input  16  operand B, two's complement
- out_valid  output  1  Z and flags hold a result from a valid input
- Z  output  16  registered sum X+Y (mod 2^16)
- Sign  output  1  Z[15]
- Zero  output  1  1 when Z == 16'h0000
- Carry  output  1  carry out of bit 15
- Parity  output  1  even-parity flag: XNOR-reduction of Z (1 when Z has an even number of ones)
- Overflow  output  1  signed overflow of the addition

## Operation
- Sum path: four 4-bit CLA slices. Per slice: generate g=X&Y, propagate p=X^Y, lookahead carries c[i+1]=g[i]|p[i]&c[i], sum s=p^c. Slice carry-in of slice 0 is 0; each slice carry-out feeds the next slice.
- Carry = carry out of slice 3 (bit 16 of the 17-bit sum).
- Overflow = (X[15] & Y[15] & ~S[15]) | (~X[15] & ~Y[15] & S[15]), where S is the unregistered sum.
- Sign, Zero and Parity are derived from the unregistered sum S and registered together with Z, so all outputs are from the same operation.
- Flags are independent of each other. Example: 16'hFFFE+16'h0002 sets Zero and Carry together.
- No subtraction, no opcode. Operation is always add.

## Timing
- On the rising edge with in_valid=1: Z, all five flags, and out_valid=1 are loaded.
- On the rising edge with in_valid=0: Z and flags hold; out_valid goes 0.
- Latency is 1 cycle from X/Y/in_valid sampled to outputs valid. Back-to-back inputs give one result per cycle.
- Reset (rst_n=0, asynchronous, any time, including mid-stream):
  - Z=16'h0000, Sign=0, Carry=0, Overflow=0, out_valid=0.
  - Zero=1 and Parity=1, consistent with Z=0.
- Release of rst_n is synchronous to clk. The first load occurs on the first rising edge after release with in_valid=1.
- Combinational path X/Y -> register D must fit one clk period. There is no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Assert rst_n=0 mid-operation -> immediately Z=0000, S=0, Zero=1, CY=0, P=1, V=0, out_valid=0.
  - Release -> outputs hold until the first in_valid.
- Mixed flags, no zero:
  - X=8FFF, Y=8000, in_valid=1 -> next cycle Z=0FFF, S=0, Zero=0, CY=1, P=1, V=1, out_valid=1.
- Zero with carry:
  - X=FFFE, Y=0002 -> Z=0000, S=0, Zero=1, CY=1, P=1, V=0.
- No carry, all ones:
  - X=AAAA, Y=5555 -> Z=FFFF, S=1, Zero=0, CY=0, P=1, V=0.
- Odd parity and carry:
  - X=FFFF, Y=FFFF -> Z=FFFE, S=1, Zero=0, CY=1, P=0, V=0.
  - Then in_valid=0 for 2 cycles -> Z/flags hold at FFFE, out_valid=0.
- Positive overflow and back-to-back:
  - X=7FFF, Y=0001 -> Z=8000, S=1, CY=0, V=1, P=0.
  - Immediately next cycle X=0000, Y=0000 -> Z=0000, Zero=1, P=1.
  - Check one result per cycle.

Source files
------------

// File: rtl/alu.sv
// 16-bit adder built from four chained 4-bit carry-lookahead slices, with a
// registered result stage carrying the sum and its sign/zero/carry/parity/overflow flags.

module alu_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are fully expanded from cin so no carry ripples inside the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  output logic        out_valid,
  output logic [15:0] Z,
  output logic        Sign,
  output logic        Zero,
  output logic        Carry,
  output logic        Parity,
  output logic        Overflow
);

  logic [15:0] sum;
  logic [4:0]  chain;
  logic        sum_sign;
  logic        sum_zero;
  logic        sum_parity;
  logic        sum_overflow;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    alu_cla4 u_cla4 (
      .a    (X[4*i +: 4]),
      .b    (Y[4*i +: 4]),
      .cin  (chain[i]),
      .sum  (sum[4*i +: 4]),
      .cout (chain[i+1])
    );
  end

  assign sum_sign     = sum[15];
  assign sum_zero     = (sum == 16'h0000);
  assign sum_parity   = ~^sum;
  assign sum_overflow = (X[15] & Y[15] & ~sum[15]) | (~X[15] & ~Y[15] & sum[15]);

  // Reset values describe Z=0, so Zero and Parity come up set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Z         <= 16'h0000;
      Sign      <= 1'b0;
      Zero      <= 1'b1;
      Carry     <= 1'b0;
      Parity    <= 1'b1;
      Overflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      out_valid <= in_valid;
      if (in_valid) begin
        Z        <= sum;
        Sign     <= sum_sign;
        Zero     <= sum_zero;
        Carry    <= chain[4];
        Parity   <= sum_parity;
        Overflow <= sum_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed flag cases, async reset, hold behaviour
// and randomized operands against an arithmetic reference model.

module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] X;
  logic [15:0] Y;
  logic        out_valid;
  logic [15:0] Z;
  logic        Sign;
  logic        Zero;
  logic        Carry;
  logic        Parity;
  logic        Overflow;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        overflow;
    logic        valid;
  } exp_t;

  exp_t m;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .Z         (Z),
    .Sign      (Sign),
    .Zero      (Zero),
    .Carry     (Carry),
    .Parity    (Parity),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_state();
    exp_t e;
    e = '{z: 16'h0000, sign: 1'b0, zero: 1'b1, carry: 1'b0,
          parity: 1'b1, overflow: 1'b0, valid: 1'b0};
    return e;
  endfunction

  // Reference: plain integer arithmetic, not a re-statement of the adder structure.
  function automatic exp_t ref_add(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int unsigned usum;
    int          ssum;
    usum       = int'(a) + int'(b);
    ssum       = int'($signed(a)) + int'($signed(b));
    e.z        = usum[15:0];
    e.carry    = (usum > 32'd65535);
    e.sign     = (e.z >= 16'h8000);
    e.zero     = (e.z == 16'd0);
    e.parity   = ($countones(e.z) % 2 == 0);
    e.overflow = (ssum > 32767) || (ssum < -32768);
    e.valid    = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_z"},        Z,                 m.z);
    check({tag, "_sign"},     {15'd0, Sign},     {15'd0, m.sign});
    check({tag, "_zero"},     {15'd0, Zero},     {15'd0, m.zero});
    check({tag, "_carry"},    {15'd0, Carry},    {15'd0, m.carry});
    check({tag, "_parity"},   {15'd0, Parity},   {15'd0, m.parity});
    check({tag, "_ovf"},      {15'd0, Overflow}, {15'd0, m.overflow});
    check({tag, "_valid"},    {15'd0, out_valid},{15'd0, m.valid});
  endtask

  // One cycle: drive at negedge, update model at posedge, sample 1 ns later.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input string tag);
    @(negedge clk);
    in_valid = v;
    X        = a;
    Y        = b;
    @(posedge clk);
    if (v) m = ref_add(a, b);
    else   m.valid = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    Y        = '0;
    m        = reset_state();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h1234, 16'h1111, "post_release_idle");
    step(1'b0, 16'h1234, 16'h1111, "post_release_idle2");

    step(1'b1, 16'h8FFF, 16'h8000, "mixed_flags");
    check("mixed_flags_lit", Z, 16'h0FFF);
    step(1'b1, 16'hFFFE, 16'h0002, "zero_carry");
    check("zero_carry_lit", {14'd0, Zero, Carry}, 16'h0003);
    step(1'b1, 16'hAAAA, 16'h5555, "all_ones");
    check("all_ones_lit", Z, 16'hFFFF);
    step(1'b1, 16'hFFFF, 16'hFFFF, "odd_parity");
    check("odd_parity_lit", {15'd0, Parity}, 16'h0000);
    step(1'b0, 16'h0101, 16'h0202, "hold1");
    step(1'b0, 16'h7777, 16'h1111, "hold2");
    check("hold_lit", Z, 16'hFFFE);

    step(1'b1, 16'h7FFF, 16'h0001, "pos_ovf");
    check("pos_ovf_lit", {15'd0, Overflow}, 16'h0001);
    step(1'b1, 16'h0000, 16'h0000, "b2b_zero");
    step(1'b1, 16'h8000, 16'h8000, "neg_ovf");
    step(1'b1, 16'h0003, 16'hFFFD, "b2b_wrap");

    // Asynchronous reset mid-stream, away from any clock edge.
    step(1'b1, 16'h1234, 16'h4321, "pre_reset");
    @(negedge clk);
    in_valid = 1'b1;
    X        = 16'h5A5A;
    Y        = 16'h0F0F;
    #2;
    rst_n = 1'b0;
    m     = reset_state();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1'b0, 16'hFFFF, 16'h0001, "release_hold");
    step(1'b1, 16'hFFFF, 16'h0001, "first_load");

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        v;
      a = 16'($urandom);
      b = 16'($urandom);
      v = ($urandom_range(0, 3) != 0);
      case (i % 10)
        0: b = 16'(-a);
        1: a = 16'h7FFF;
        2: a = 16'h8000;
        default: ;
      endcase
      step(v, a, b, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
